// File: rtl/booth_r4_controller.sv
// Sequencing FSM for the radix-4 Booth multiplier (IDLE->LOAD->{EVAL,SHIFT}xN/2->DONE).
// Latency: start sampled at edge 0 -> done pulse in cycle N_BITS+2; one op per N_BITS+3 cycles.
// Backpressure: none; start is ignored while busy (no queuing, no error flag).
//
// Ports:
//   clk, rst      rising-edge clock, asynchronous active-high reset
//   start         request a multiplication, honoured only in IDLE
//   q_bits        recode triplet {Q[1],Q[0],Q_-1} from the datapath, used in EVAL
//   load          load M and Q, clear A and Q_-1
//   add_en/c4/c3  adder capture enable, 2M select, subtract select (EVAL only)
//   shift         arithmetic shift right by 2 of {A,Q,Q_-1}
//   busy, done    busy LOAD..DONE inclusive; done is a one-cycle product-valid pulse
//   iter          current recode iteration, for debug
module booth_r4_controller #(
  parameter int N_BITS = 8,
  parameter int CNT_W  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       q_bits,
  output logic             load,
  output logic             add_en,
  output logic             c3,
  output logic             c4,
  output logic             shift,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] iter
);

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(N_BITS / 2 - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_EVAL,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] iter_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      iter  <= '0;
    end else begin
      state <= state_nxt;
      iter  <= iter_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    iter_nxt  = iter;
    load      = 1'b0;
    add_en    = 1'b0;
    c3        = 1'b0;
    c4        = 1'b0;
    shift     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_LOAD;
      end

      S_LOAD: begin
        load      = 1'b1;
        busy      = 1'b1;
        iter_nxt  = '0;
        state_nxt = S_EVAL;
      end

      S_EVAL: begin
        busy      = 1'b1;
        state_nxt = S_SHIFT;
        // Radix-4 Booth recode: the triplet selects 0, +-M or +-2M.
        // 000 and 111 leave A untouched, so no adder capture.
        case (q_bits)
          3'b001, 3'b010: add_en = 1'b1;
          3'b011: begin
            add_en = 1'b1;
            c4     = 1'b1;
          end
          3'b100: begin
            add_en = 1'b1;
            c4     = 1'b1;
            c3     = 1'b1;
          end
          3'b101, 3'b110: begin
            add_en = 1'b1;
            c3     = 1'b1;
          end
          default: ;
        endcase
      end

      S_SHIFT: begin
        shift = 1'b1;
        busy  = 1'b1;
        if (iter == LAST_ITER) begin
          state_nxt = S_DONE;
        end else begin
          iter_nxt  = iter + CNT_W'(1);
          state_nxt = S_EVAL;
        end
      end

      S_DONE: begin
        done      = 1'b1;
        busy      = 1'b1;
        state_nxt = S_IDLE;
      end

      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_booth_r4_controller.sv
// Directed bench for booth_r4_controller with a small behavioural A/Q/Q_-1 datapath.
module tb_booth_r4_controller;

  localparam int N_BITS = 8;
  localparam int CNT_W  = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [2:0]       q_bits;
  logic             load, add_en, c3, c4, shift, busy, done;
  logic [CNT_W-1:0] iter;

  // q_bits comes either from the datapath model or straight from the bench
  logic       use_model;
  logic [2:0] q_force;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  booth_r4_controller #(.N_BITS(N_BITS), .CNT_W(CNT_W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .q_bits (q_bits),
    .load   (load),
    .add_en (add_en),
    .c3     (c3),
    .c4     (c4),
    .shift  (shift),
    .busy   (busy),
    .done   (done),
    .iter   (iter)
  );

  // Behavioural multiplier datapath: 10-bit A, 8-bit Q, Q_-1, 8-bit M.
  logic signed [9:0]  dp_a;
  logic        [7:0]  dp_q, dp_m;
  logic               dp_q1;
  logic        [7:0]  m_in, q_in;
  logic signed [9:0]  mop, addend;
  logic signed [18:0] cat, shifted;
  logic        [15:0] product;

  always_comb begin
    mop     = c4 ? {dp_m[7], dp_m, 1'b0} : {{2{dp_m[7]}}, dp_m};
    addend  = c3 ? -mop : mop;
    cat     = {dp_a, dp_q, dp_q1};
    shifted = cat >>> 2;
    product = {dp_a[7:0], dp_q};
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      dp_a  <= '0;
      dp_q  <= '0;
      dp_q1 <= 1'b0;
      dp_m  <= '0;
    end else if (load) begin
      dp_a  <= '0;
      dp_q  <= q_in;
      dp_q1 <= 1'b0;
      dp_m  <= m_in;
    end else if (add_en) begin
      dp_a <= dp_a + addend;
    end else if (shift) begin
      {dp_a, dp_q, dp_q1} <= shifted;
    end
  end

  assign q_bits = use_model ? {dp_q[1], dp_q[0], dp_q1} : q_force;

  // Expected vectors
  logic [2:0]  rec_tbl [8] = '{3'b000, 3'b100, 3'b100, 3'b110, 3'b111, 3'b101, 3'b101, 3'b000};
  logic [2:0]  t4_trip [4] = '{3'b110, 3'b011, 3'b000, 3'b000};
  logic [2:0]  t4_ops  [4] = '{3'b101, 3'b110, 3'b000, 3'b000};
  logic [7:0]  t6_m    [3] = '{8'h7F, 8'hFF, 8'h00};
  logic [7:0]  t6_q    [3] = '{8'h80, 8'hFF, 8'hA5};
  logic [15:0] t6_p    [3] = '{16'hC080, 16'h0001, 16'h0000};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  int load_cyc[$];
  int done_cnt;
  int n;

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    use_model = 1'b1;
    q_force   = 3'b000;
    m_in      = 8'h00;
    q_in      = 8'h00;

    // Reset state
    #12;
    check("rst_strobes", {load, add_en, c3, c4, shift, busy, done}, 7'b0);
    check("rst_iter", iter, 0);
    @(negedge clk);
    rst = 1'b0;
    step();
    check("idle_busy", busy, 1'b0);

    // T2: handshake timing for a single op
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      check($sformatf("t2_load_c%0d", c), load, (c == 1));
      check($sformatf("t2_shift_c%0d", c), shift, (c >= 3 && c <= 9 && (c % 2) == 1));
      check($sformatf("t2_done_c%0d", c), done, (c == 10));
      check($sformatf("t2_busy_c%0d", c), busy, (c >= 1 && c <= 10));
      if (c == 9) check("t2_iter_last", iter, N_BITS / 2 - 1);
      step();
    end

    // T3: recode sweep with forced triplets, two operations of four EVALs
    use_model = 1'b0;
    for (int op = 0; op < 2; op++) begin
      start = 1'b1;
      step();
      start = 1'b0;
      for (int k = 0; k < 4; k++) begin
        step();
        q_force = 3'(op * 4 + k);
        #1;
        check($sformatf("t3_recode_%0d", op * 4 + k), {add_en, c4, c3}, rec_tbl[op * 4 + k]);
        check($sformatf("t3_iter_%0d", op * 4 + k), iter, k);
        q_force = 3'b100;
        step();
        check($sformatf("t3_shift_gate_%0d", op * 4 + k), {shift, add_en, c4, c3}, 4'b1000);
      end
      step();
      step();
    end
    use_model = 1'b1;

    // T4: multiplier 0x07 against the datapath model, multiplicand 3
    m_in  = 8'h03;
    q_in  = 8'h07;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("t4_trip_%0d", k), q_bits, t4_trip[k]);
      check($sformatf("t4_ops_%0d", k), {add_en, c4, c3}, t4_ops[k]);
      step();
    end
    step();
    check("t4_done", done, 1'b1);
    check("t4_product", product, 16'h0015);
    step();

    // T5: start held high -> back-to-back operations 11 cycles apart
    start = 1'b1;
    done_cnt = 0;
    step();
    for (int c = 1; c <= 40; c++) begin
      if (load) load_cyc.push_back(c);
      if (done) done_cnt++;
      step();
    end
    start = 1'b0;
    check("t5_load_count", load_cyc.size(), 4);
    for (int i = 0; i < 4 && i < load_cyc.size(); i++)
      check($sformatf("t5_load_at_%0d", i), load_cyc[i], 1 + 11 * i);
    check("t5_done_count", done_cnt, 3);
    n = 0;
    while (busy && n < 20) begin
      step();
      n++;
    end
    check("t5_drain", busy, 1'b0);

    // T6: end-to-end signed products
    for (int t = 0; t < 3; t++) begin
      m_in  = t6_m[t];
      q_in  = t6_q[t];
      start = 1'b1;
      step();
      start = 1'b0;
      n = 0;
      while (!done && n < 20) begin
        step();
        n++;
      end
      check($sformatf("t6_done_%0d", t), done, 1'b1);
      check($sformatf("t6_latency_%0d", t), n, N_BITS + 1);
      check($sformatf("t6_product_%0d", t), product, t6_p[t]);
      step();
    end

    // T1: asynchronous reset in the middle of EVAL at iter=2
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 2; c <= 6; c++) step();
    use_model = 1'b0;
    q_force   = 3'b011;
    #1;
    check("t1_pre_iter", iter, 2);
    check("t1_pre_add_en", add_en, 1'b1);
    rst = 1'b1;
    #1;
    check("t1_rst_strobes", {load, add_en, c3, c4, shift, busy, done}, 7'b0);
    check("t1_rst_iter", iter, 0);
    @(negedge clk);
    rst = 1'b0;
    step();
    check("t1_idle", busy, 1'b0);
    start = 1'b1;
    step();
    start = 1'b0;
    check("t1_restart_load", load, 1'b1);
    use_model = 1'b1;

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
